writeback_queue: RTL and testbench

Buffers register-file write-backs from the execute stage and drains them into the register file write port, one per cycle, whenever draining is enabled. It sits directly upstream of `registerfile`, driving its `write_enable`/`write_address`/`write_data`. While writes wait in the queue, it forwards the youngest pending data on matching register reads, so operand fetch never sees stale values.

---
 rtl/writeback_queue.sv | 104 ++++++++++
 tb/tb_writeback_queue.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_queue.sv
// rtl/writeback_queue.sv - write-back FIFO feeding the register file write port, with operand forwarding
// Youngest pending write to a register wins on reads; $0 writes are acknowledged and dropped.
module writeback_queue #(
  parameter int depth = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [4:0]                 in_address,
  input  logic [31:0]                in_data,
  input  logic                       drain_enable,
  output logic                       write_enable,
  output logic [4:0]                 write_address,
  output logic [31:0]                write_data,
  input  logic [4:0]                 read_address_1,
  input  logic [4:0]                 read_address_2,
  input  logic [31:0]                read_data_1,
  input  logic [31:0]                read_data_2,
  output logic [31:0]                fwd_data_1,
  output logic [31:0]                fwd_data_2,
  output logic [$clog2(depth):0]     count
);

  localparam int aw = $clog2(depth);
  localparam int cw = aw + 1;

  logic [aw-1:0] head_q, head_d;
  logic [aw-1:0] tail_q, tail_d;
  logic [cw-1:0] count_q, count_d;
  logic [4:0]    addr_q [depth];
  logic [4:0]    addr_d [depth];
  logic [31:0]   data_q [depth];
  logic [31:0]   data_d [depth];

  logic push;
  logic pop;

  assign in_ready      = (count_q < cw'(depth));
  assign write_enable  = (count_q != '0) && drain_enable;
  assign write_address = (count_q != '0) ? addr_q[head_q] : 5'd0;
  assign write_data    = (count_q != '0) ? data_q[head_q] : 32'd0;
  assign count         = count_q;

  assign push = in_valid && in_ready && (in_address != 5'd0);
  assign pop  = write_enable;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    addr_d  = addr_q;
    data_d  = data_q;
    if (push) begin
      addr_d[tail_q] = in_address;
      data_d[tail_q] = in_data;
      tail_d         = tail_q + aw'(1);
    end
    if (pop) begin
      head_d = head_q + aw'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + cw'(1);
      2'b01:   count_d = count_q - cw'(1);
      default: count_d = count_q;
    endcase
  end

  // Scan oldest to youngest so the last hit is the most recent write.
  always_comb begin
    logic [aw-1:0] idx;
    idx        = head_q;
    fwd_data_1 = read_data_1;
    fwd_data_2 = read_data_2;
    for (int i = 0; i < depth; i++) begin
      idx = head_q + aw'(i);
      if (cw'(i) < count_q) begin
        if (addr_q[idx] == read_address_1) fwd_data_1 = data_q[idx];
        if (addr_q[idx] == read_address_2) fwd_data_2 = data_q[idx];
      end
    end
    if (read_address_1 == 5'd0) fwd_data_1 = 32'd0;
    if (read_address_2 == 5'd0) fwd_data_2 = 32'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < depth; i++) begin
        addr_q[i] <= 5'd0;
        data_q[i] <= 32'd0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: tb/tb_writeback_queue.sv
// tb/tb_writeback_queue.sv - directed self-checking bench for writeback_queue
// A behavioural register file captures the drained writes so commits can be checked.
module tb_writeback_queue;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_address;
  logic [31:0] in_data;
  logic        drain_enable;
  logic        write_enable;
  logic [4:0]  write_address;
  logic [31:0] write_data;
  logic [4:0]  read_address_1, read_address_2;
  logic [31:0] read_data_1, read_data_2;
  logic [31:0] fwd_data_1, fwd_data_2;
  logic [2:0]  count;

  int tests;
  int failed;

  logic [31:0] rf [32];

  writeback_queue #(.depth(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_address(in_address), .in_data(in_data),
    .drain_enable(drain_enable),
    .write_enable(write_enable), .write_address(write_address), .write_data(write_data),
    .read_address_1(read_address_1), .read_address_2(read_address_2),
    .read_data_1(read_data_1), .read_data_2(read_data_2),
    .fwd_data_1(fwd_data_1), .fwd_data_2(fwd_data_2),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (write_enable) rf[write_address] <= write_data;
  end

  task automatic push_one(input logic [4:0] a, input logic [31:0] d);
    in_valid   = 1'b1;
    in_address = a;
    in_data    = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    read_address_1 = 5'd3;
    read_data_1    = 32'h5555_AAAA;
    #1;
    tests++; if (count !== 3'd0) begin failed++; $display("FAIL reset_count got %0d exp 0", count); end
    tests++; if (in_ready !== 1'b1) begin failed++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    tests++; if (write_enable !== 1'b0) begin failed++; $display("FAIL reset_write_enable got %b exp 0", write_enable); end
    tests++; if (fwd_data_1 !== 32'h5555_AAAA) begin failed++; $display("FAIL reset_fwd got %h exp 5555aaaa", fwd_data_1); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single;
    drain_enable   = 1'b1;
    read_address_1 = 5'd5;
    read_data_1    = 32'd0;
    push_one(5'd5, 32'hDEAD_BEEF);
    tests++; if (write_enable !== 1'b1) begin failed++; $display("FAIL single_we got %b exp 1", write_enable); end
    tests++; if (write_address !== 5'd5) begin failed++; $display("FAIL single_addr got %0d exp 5", write_address); end
    tests++; if (write_data !== 32'hDEAD_BEEF) begin failed++; $display("FAIL single_data got %h exp deadbeef", write_data); end
    tests++; if (fwd_data_1 !== 32'hDEAD_BEEF) begin failed++; $display("FAIL single_fwd got %h exp deadbeef", fwd_data_1); end
    @(posedge clk); #1;
    tests++; if (count !== 3'd0) begin failed++; $display("FAIL single_count got %0d exp 0", count); end
    tests++; if (rf[5] !== 32'hDEAD_BEEF) begin failed++; $display("FAIL single_commit got %h exp deadbeef", rf[5]); end
    tests++; if (write_enable !== 1'b0) begin failed++; $display("FAIL single_we_after got %b exp 0", write_enable); end
  endtask

  task automatic test_full;
    drain_enable = 1'b0;
    for (int i = 0; i < 4; i++) push_one(5'(i + 1), 32'h100 + 32'(i));
    tests++; if (count !== 3'd4) begin failed++; $display("FAIL full_count got %0d exp 4", count); end
    tests++; if (in_ready !== 1'b0) begin failed++; $display("FAIL full_in_ready got %b exp 0", in_ready); end
    tests++; if (write_address !== 5'd1) begin failed++; $display("FAIL full_hold_addr got %0d exp 1", write_address); end
    push_one(5'd9, 32'h999);
    tests++; if (count !== 3'd4) begin failed++; $display("FAIL full_reject got %0d exp 4", count); end
    drain_enable = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      tests++; if (write_address !== 5'(k + 1) || write_data !== 32'h100 + 32'(k)) begin
        failed++; $display("FAIL full_order_%0d got %0d/%h exp %0d/%h", k, write_address, write_data, k + 1, 32'h100 + 32'(k));
      end
      @(posedge clk); #1;
      if (k == 0) begin
        tests++; if (in_ready !== 1'b1 || count !== 3'd3) begin
          failed++; $display("FAIL full_ready_after_pop got ready=%b count=%0d exp 1/3", in_ready, count);
        end
      end
    end
    tests++; if (count !== 3'd0) begin failed++; $display("FAIL full_drained got %0d exp 0", count); end
    tests++; if (rf[4] !== 32'h103) begin failed++; $display("FAIL full_commit got %h exp 103", rf[4]); end
  endtask

  task automatic test_forward;
    drain_enable = 1'b0;
    read_address_1 = 5'd7;
    read_data_1    = 32'd0;
    read_address_2 = 5'd7;
    read_data_2    = 32'hFFFF;
    push_one(5'd7, 32'h11);
    push_one(5'd7, 32'h22);
    tests++; if (fwd_data_1 !== 32'h22) begin failed++; $display("FAIL fwd_youngest_1 got %h exp 22", fwd_data_1); end
    tests++; if (fwd_data_2 !== 32'h22) begin failed++; $display("FAIL fwd_youngest_2 got %h exp 22", fwd_data_2); end
    read_address_2 = 5'd8;
    #1;
    tests++; if (fwd_data_2 !== 32'hFFFF) begin failed++; $display("FAIL fwd_nomatch got %h exp ffff", fwd_data_2); end
    drain_enable = 1'b1;
    @(posedge clk); #1;
    tests++; if (fwd_data_1 !== 32'h22) begin failed++; $display("FAIL fwd_partial got %h exp 22", fwd_data_1); end
    @(posedge clk); #1;
    tests++; if (rf[7] !== 32'h22 || count !== 3'd0) begin
      failed++; $display("FAIL fwd_commit got %h count=%0d exp 22/0", rf[7], count);
    end
  endtask

  task automatic test_zero;
    drain_enable = 1'b1;
    in_valid     = 1'b1;
    in_address   = 5'd0;
    in_data      = 32'hFFFF_FFFF;
    #1;
    tests++; if (in_ready !== 1'b1) begin failed++; $display("FAIL zero_ready got %b exp 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    tests++; if (count !== 3'd0 || write_enable !== 1'b0) begin
      failed++; $display("FAIL zero_dropped got count=%0d we=%b exp 0/0", count, write_enable);
    end
    read_address_2 = 5'd0;
    read_data_2    = 32'h1234;
    #1;
    tests++; if (fwd_data_2 !== 32'd0) begin failed++; $display("FAIL zero_read got %h exp 0", fwd_data_2); end
  endtask

  task automatic test_wrap;
    logic [36:0] exp_q [$];
    int pushed;
    int committed;
    int cyc;
    logic acc;
    logic pop_now;
    pushed    = 0;
    committed = 0;
    cyc       = 0;
    while ((pushed < 10 || exp_q.size() != 0) && cyc < 100) begin
      in_valid     = (pushed < 10);
      in_address   = 5'(pushed + 1);
      in_data      = 32'hA000 + 32'(pushed);
      drain_enable = cyc[0] | (pushed >= 10);
      #1;
      acc     = in_valid && (exp_q.size() < 4);
      pop_now = (exp_q.size() != 0) && drain_enable;
      tests++; if (in_ready !== (exp_q.size() < 4) || write_enable !== pop_now) begin
        failed++; $display("FAIL wrap_ctrl_c%0d got ready=%b we=%b exp %b/%b", cyc, in_ready, write_enable, exp_q.size() < 4, pop_now);
      end
      if (pop_now) begin
        tests++; if ({write_address, write_data} !== exp_q[0]) begin
          failed++; $display("FAIL wrap_data_c%0d got %0d/%h exp %0d/%h", cyc, write_address, write_data, exp_q[0][36:32], exp_q[0][31:0]);
        end
      end
      @(posedge clk);
      if (pop_now) begin
        void'(exp_q.pop_front());
        committed++;
      end
      if (acc) begin
        exp_q.push_back({in_address, in_data});
        pushed++;
      end
      #1;
      cyc++;
    end
    in_valid = 1'b0;
    tests++; if (committed != 10 || count !== 3'd0) begin
      failed++; $display("FAIL wrap_total got %0d writes count=%0d exp 10/0", committed, count);
    end
    tests++; if (rf[10] !== 32'hA009 || rf[1] !== 32'hA000) begin
      failed++; $display("FAIL wrap_commit got %h/%h exp a000/a009", rf[1], rf[10]);
    end
  endtask

  task automatic test_reset_mid;
    drain_enable = 1'b0;
    push_one(5'd20, 32'h20);
    push_one(5'd21, 32'h21);
    push_one(5'd22, 32'h22);
    tests++; if (count !== 3'd3) begin failed++; $display("FAIL rstmid_pending got %0d exp 3", count); end
    #2;
    rst_n = 1'b0;
    drain_enable = 1'b1;
    #1;
    tests++; if (count !== 3'd0 || write_enable !== 1'b0) begin
      failed++; $display("FAIL rstmid_clear got count=%0d we=%b exp 0/0", count, write_enable);
    end
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    push_one(5'd12, 32'hABC);
    tests++; if (write_address !== 5'd12 || write_data !== 32'hABC) begin
      failed++; $display("FAIL rstmid_first got %0d/%h exp 12/abc", write_address, write_data);
    end
    @(posedge clk); #1;
    tests++; if (rf[12] !== 32'hABC || rf[20] === 32'h20) begin
      failed++; $display("FAIL rstmid_commit got %h/%h exp abc/not-20", rf[12], rf[20]);
    end
  endtask

  initial begin
    tests = 0;
    failed = 0;
    for (int i = 0; i < 32; i++) rf[i] = 32'd0;
    in_valid = 1'b0;
    in_address = 5'd0;
    in_data = 32'd0;
    drain_enable = 1'b0;
    read_address_1 = 5'd0;
    read_address_2 = 5'd0;
    read_data_1 = 32'd0;
    read_data_2 = 32'd0;
    rst_n = 1'b1;
    #2;
    test_reset;
    test_single;
    test_full;
    test_forward;
    test_zero;
    test_wrap;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
